// File: rtl/vmem_lane_packer_if.sv
// Store-request and packed-word handshake bundle for vmem_lane_packer.
// slave = packer side, master = store unit / memory side.
interface vmem_lane_packer_if #(
  parameter int unsigned INWIDTH   = 128,
  parameter int unsigned LANES     = 16,
  parameter int unsigned LANEWIDTH = 8,
  parameter int unsigned SELWIDTH  = 4
);
  localparam int unsigned NSLOT = INWIDTH / LANEWIDTH;

  logic                         in_valid;
  logic                         in_ready;
  logic [LANES*LANEWIDTH-1:0]   in_data;
  logic [LANES*SELWIDTH-1:0]    in_sel;
  logic [LANES-1:0]             in_lane_en;
  logic                         out_valid;
  logic                         out_ready;
  logic [INWIDTH-1:0]           out_data;
  logic [NSLOT-1:0]             out_byteen;
  logic                         out_last;

  modport master (
    output in_valid, in_data, in_sel, in_lane_en, out_ready,
    input  in_ready, out_valid, out_data, out_byteen, out_last
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_lane_en, out_ready,
    output in_ready, out_valid, out_data, out_byteen, out_last
  );
endinterface

// File: rtl/vmem_lane_packer.sv
// Packs per-lane store data into memory words with byte enables; same-slot lane conflicts
// are serialised over extra words. Optional conflict counter: define VMEM_PACK_STATS_EN.
module vmem_lane_packer #(
  parameter int unsigned INWIDTH   = 128,
  parameter int unsigned LANES     = 16,
  parameter int unsigned LANEWIDTH = 8,
  parameter int unsigned SELWIDTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  vmem_lane_packer_if.slave  bus
`ifdef VMEM_PACK_STATS_EN
  ,
  output logic [15:0]        stat_conflicts
`endif
);
  localparam int unsigned NSLOT = INWIDTH / LANEWIDTH;
  localparam int unsigned DW    = LANES * LANEWIDTH;
  localparam int unsigned SW    = LANES * SELWIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [INWIDTH-1:0] out_data_q, out_data_d;
  logic [NSLOT-1:0]   out_byteen_q, out_byteen_d;
  logic               out_last_q, out_last_d;
  logic [DW-1:0]      data_q, data_d;
  logic [SW-1:0]      sel_q, sel_d;
  logic [LANES-1:0]   pending_q, pending_d;
  logic               load;
`ifdef VMEM_PACK_STATS_EN
  logic               first_q, first_d;
  logic [15:0]        stat_q, stat_d;
`endif

  logic [DW-1:0]         src_data;
  logic [SW-1:0]         src_sel;
  logic [LANES-1:0]      src_pend;
  logic [INWIDTH-1:0]    pass_data;
  logic [NSLOT-1:0]      pass_byteen;
  logic [LANES-1:0]      pass_clear;
  logic [LANES-1:0]      pass_rem;
  logic [SELWIDTH-1:0]   slot;

  // Pass 0 comes straight from the request; later passes from the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      src_data = bus.in_data;
      src_sel  = bus.in_sel;
      src_pend = bus.in_lane_en;
    end else begin
      src_data = data_q;
      src_sel  = sel_q;
      src_pend = pending_q;
    end
  end

  // One pass: ascending lane scan, first pending lane to claim a slot wins it.
  always_comb begin
    pass_data   = '0;
    pass_byteen = '0;
    pass_clear  = '0;
    slot        = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      slot = src_sel[k*SELWIDTH +: SELWIDTH];
      if (src_pend[k] && !pass_byteen[slot]) begin
        pass_byteen[slot]                                = 1'b1;
        pass_data[int'(slot)*LANEWIDTH +: LANEWIDTH]     = src_data[k*LANEWIDTH +: LANEWIDTH];
        pass_clear[k]                                    = 1'b1;
      end
    end
    pass_rem = src_pend & ~pass_clear;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_byteen_d = out_byteen_q;
    out_last_d   = out_last_q;
    data_d       = data_q;
    sel_d        = sel_q;
    pending_d    = pending_q;
    load         = 1'b0;
`ifdef VMEM_PACK_STATS_EN
    first_d      = first_q;
    stat_d       = stat_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          data_d = bus.in_data;
          sel_d  = bus.in_sel;
          // An all-disabled request is consumed without producing a word.
          if (|bus.in_lane_en) begin
            state_d = EMIT;
            load    = 1'b1;
`ifdef VMEM_PACK_STATS_EN
            first_d = 1'b1;
`endif
          end
        end
      end
      EMIT: begin
        if (out_valid_q && bus.out_ready) begin
`ifdef VMEM_PACK_STATS_EN
          if (!first_q && (stat_q != 16'hFFFF)) stat_d = stat_q + 16'd1;
          first_d = 1'b0;
`endif
          if (out_last_q) begin
            state_d      = IDLE;
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            out_byteen_d = '0;
            out_last_d   = 1'b0;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_valid_d  = 1'b1;
      out_data_d   = pass_data;
      out_byteen_d = pass_byteen;
      out_last_d   = (pass_rem == '0);
      pending_d    = pass_rem;
    end

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_byteen_q <= '0;
      out_last_q   <= 1'b0;
      data_q       <= '0;
      sel_q        <= '0;
      pending_q    <= '0;
`ifdef VMEM_PACK_STATS_EN
      first_q      <= 1'b0;
      stat_q       <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_byteen_q <= out_byteen_d;
      out_last_q   <= out_last_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      pending_q    <= pending_d;
`ifdef VMEM_PACK_STATS_EN
      first_q      <= first_d;
      stat_q       <= stat_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_byteen = out_byteen_q;
  assign bus.out_last   = out_last_q;
`ifdef VMEM_PACK_STATS_EN
  assign stat_conflicts = stat_q;
`endif

endmodule

// File: tb/tb_vmem_lane_packer.sv
// Scoreboard bench for vmem_lane_packer; expected words come from a per-slot rank model.
module tb_vmem_lane_packer;
  localparam int unsigned INWIDTH   = 128;
  localparam int unsigned LANES     = 16;
  localparam int unsigned LANEWIDTH = 8;
  localparam int unsigned SELWIDTH  = 4;
  localparam int unsigned NSLOT     = 16;

  typedef struct packed {
    logic [INWIDTH-1:0] data;
    logic [NSLOT-1:0]   byteen;
    logic               last;
    logic               first;
  } word_t;

  logic clk = 1'b0;
  logic reset;
`ifdef VMEM_PACK_STATS_EN
  logic [15:0] stat_conflicts;
`endif

  vmem_lane_packer_if #(.INWIDTH(INWIDTH), .LANES(LANES), .LANEWIDTH(LANEWIDTH), .SELWIDTH(SELWIDTH)) bus ();

  vmem_lane_packer #(.INWIDTH(INWIDTH), .LANES(LANES), .LANEWIDTH(LANEWIDTH), .SELWIDTH(SELWIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef VMEM_PACK_STATS_EN
    ,
    .stat_conflicts (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  word_t exp_q[$];
  int    errors   = 0;
  int    checks   = 0;
  int    exp_stat = 0;

  // Word index of a lane = its rank among enabled lanes targeting the same slot.
  function automatic void model_push(input logic [15:0] en, input logic [63:0] sel, input logic [127:0] data);
    word_t w[16];
    int    pos;
    int    nwords = 0;
    logic [3:0] sk;
    for (int i = 0; i < 16; i++) w[i] = '0;
    for (int k = 0; k < 16; k++) begin
      if (en[k]) begin
        sk  = sel[k*4 +: 4];
        pos = 0;
        for (int j = 0; j < k; j++) if (en[j] && (sel[j*4 +: 4] == sk)) pos++;
        w[pos].data[int'(sk)*8 +: 8] = data[k*8 +: 8];
        w[pos].byteen[sk]            = 1'b1;
        if (pos + 1 > nwords) nwords = pos + 1;
      end
    end
    for (int i = 0; i < nwords; i++) begin
      w[i].last  = (i == nwords - 1);
      w[i].first = (i == 0);
      exp_q.push_back(w[i]);
    end
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] en, input logic [63:0] sel, input logic [127:0] data);
    int b = 0;
    while (bus.in_ready !== 1'b1 && b < 40) begin @(negedge clk); b++; end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL send_ready: in_ready=%b want 1", bus.in_ready); end
    bus.in_valid   = 1'b1;
    bus.in_data    = data;
    bus.in_sel     = sel;
    bus.in_lane_en = en;
    model_push(en, sel, data);
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.in_data    = {$urandom, $urandom, $urandom, $urandom};
    bus.in_sel     = {$urandom, $urandom};
    bus.in_lane_en = 16'($urandom);
  endtask

  // Drains the scoreboard; optionally stalls word hold_at for hold_len cycles.
  task automatic collect(input int hold_at, input int hold_len, input bit rnd, input int budget);
    int    w = 0, cyc = 0, held = 0;
    bit    snap_ok = 1'b0;
    logic  rdy;
    word_t e, snap;
    snap = '0;
    while (exp_q.size() > 0 && cyc < budget) begin
      if (w == hold_at && held < hold_len && bus.out_valid === 1'b1) begin
        rdy = 1'b0;
        if (snap_ok) begin
          checks++;
          if ({bus.out_data, bus.out_byteen, bus.out_last} !== {snap.data, snap.byteen, snap.last}) begin
            errors++; $display("FAIL hold_stable: got %h/%h/%b want %h/%h/%b", bus.out_data, bus.out_byteen, bus.out_last, snap.data, snap.byteen, snap.last);
          end
        end else begin
          snap.data = bus.out_data; snap.byteen = bus.out_byteen; snap.last = bus.out_last; snap_ok = 1'b1;
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b want 0", bus.in_ready); end
        held++;
      end else begin
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      bus.out_ready = rdy;
      if (bus.out_valid === 1'b1 && rdy) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.out_data !== e.data) begin errors++; $display("FAIL word%0d_data: got %h want %h", w, bus.out_data, e.data); end
        checks++;
        if (bus.out_byteen !== e.byteen) begin errors++; $display("FAIL word%0d_byteen: got %h want %h", w, bus.out_byteen, e.byteen); end
        checks++;
        if (bus.out_last !== e.last) begin errors++; $display("FAIL word%0d_last: got %b want %b", w, bus.out_last, e.last); end
        if (!e.first) exp_stat++;
        w++;
        if (e.last) begin
          @(negedge clk); cyc++;
          checks++;
          if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL gap_after_last: out_valid=%b want 0", bus.out_valid); end
          continue;
        end
      end
      @(negedge clk); cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL collect_timeout: %0d words outstanding want 0", exp_q.size());
      exp_q.delete();
    end
    bus.out_ready = 1'b0;
`ifdef VMEM_PACK_STATS_EN
    checks++;
    if (stat_conflicts !== 16'(exp_stat)) begin errors++; $display("FAIL stat_conflicts: got %0d want %0d", stat_conflicts, exp_stat); end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready   !== 1'b0)  begin errors++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid  !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data   !== '0)    begin errors++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
    checks++; if (bus.out_byteen !== '0)    begin errors++; $display("FAIL rst_out_byteen: got %h want 0", bus.out_byteen); end
    checks++; if (bus.out_last   !== 1'b0)  begin errors++; $display("FAIL rst_out_last: got %b want 0", bus.out_last); end
    reset = 1'b0;
    exp_stat = 0;
    @(negedge clk);
    checks++; if (bus.in_ready   !== 1'b1)  begin errors++; $display("FAIL post_rst_in_ready: got %b want 1", bus.in_ready); end
`ifdef VMEM_PACK_STATS_EN
    checks++; if (stat_conflicts !== 16'd0) begin errors++; $display("FAIL rst_stat: got %0d want 0", stat_conflicts); end
`endif
  endtask

  task automatic test_identity();
    logic [63:0]  sel;
    logic [127:0] data;
    for (int k = 0; k < 16; k++) begin sel[k*4 +: 4] = 4'(k); data[k*8 +: 8] = 8'(16 + k); end
    send(16'hFFFF, sel, data);
    checks++; if (bus.out_valid  !== 1'b1) begin errors++; $display("FAIL id_latency: out_valid=%b want 1", bus.out_valid); end
    checks++; if (bus.out_data   !== 128'h1F1E1D1C1B1A19181716151413121110) begin errors++; $display("FAIL id_data: got %h want 1f1e..1110", bus.out_data); end
    checks++; if (bus.out_byteen !== 16'hFFFF) begin errors++; $display("FAIL id_byteen: got %h want ffff", bus.out_byteen); end
    checks++; if (bus.out_last   !== 1'b1) begin errors++; $display("FAIL id_last: got %b want 1", bus.out_last); end
    checks++; if (bus.in_ready   !== 1'b0) begin errors++; $display("FAIL id_in_ready: got %b want 0", bus.in_ready); end
    collect(-1, 0, 1'b0, 20);
  endtask

  task automatic test_full_conflict();
    logic [63:0]  sel;
    logic [127:0] data;
    for (int k = 0; k < 16; k++) begin sel[k*4 +: 4] = 4'h3; data[k*8 +: 8] = 8'(k); end
    send(16'hFFFF, sel, data);
    collect(-1, 0, 1'b0, 60);
`ifdef VMEM_PACK_STATS_EN
    checks++; if (stat_conflicts !== 16'd15) begin errors++; $display("FAIL full_stat: got %0d want 15", stat_conflicts); end
`endif
  endtask

  task automatic test_partial();
    logic [63:0]  sel;
    logic [127:0] data, w0;
    sel  = {$urandom, $urandom};
    data = {$urandom, $urandom, $urandom, $urandom};
    sel[3:0]   = 4'h7; data[7:0]   = 8'hAA;
    sel[11:8]  = 4'h7; data[23:16] = 8'hBB;
    w0 = '0; w0[63:56] = 8'hAA;
    send(16'h0005, sel, data);
    checks++; if (bus.out_valid  !== 1'b1)     begin errors++; $display("FAIL part_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data   !== w0)       begin errors++; $display("FAIL part_w0_data: got %h want %h", bus.out_data, w0); end
    checks++; if (bus.out_byteen !== 16'h0080) begin errors++; $display("FAIL part_w0_byteen: got %h want 0080", bus.out_byteen); end
    checks++; if (bus.out_last   !== 1'b0)     begin errors++; $display("FAIL part_w0_last: got %b want 0", bus.out_last); end
    collect(-1, 0, 1'b0, 20);
  endtask

  task automatic test_backpressure();
    logic [63:0]  sel;
    logic [127:0] data;
    for (int k = 0; k < 16; k++) begin sel[k*4 +: 4] = 4'hC; data[k*8 +: 8] = 8'(8'h40 + k); end
    send(16'hFFFF, sel, data);
    collect(5, 5, 1'b0, 80);
  endtask

  task automatic test_empty();
    send(16'h0000, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL empty_valid%0d: got %b want 0", i, bus.out_valid); end
      checks++; if (bus.in_ready  !== 1'b1) begin errors++; $display("FAIL empty_ready%0d: got %b want 1", i, bus.in_ready); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [63:0]  sel;
    logic [127:0] data;
    logic [15:0]  en;
    for (int r = 0; r < 10; r++) begin
      en   = (r % 3 == 0) ? 16'hFFFF : 16'($urandom);
      data = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 16; k++) sel[k*4 +: 4] = 4'($urandom_range(0, 3));
      send(en, sel, data);
      collect(-1, 0, 1'b1, 400);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0]  sel;
    logic [127:0] data;
    word_t        e;
    int           w = 0, cyc = 0;
    for (int k = 0; k < 16; k++) begin sel[k*4 +: 4] = 4'h5; data[k*8 +: 8] = 8'(8'h80 + k); end
    send(16'hFFFF, sel, data);
    bus.out_ready = 1'b1;
    while (w < 2 && cyc < 50) begin
      if (bus.out_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++; if (bus.out_data !== e.data) begin errors++; $display("FAIL rmid_word%0d: got %h want %h", w, bus.out_data, e.data); end
        if (!e.first) exp_stat++;
        w++;
      end
      @(negedge clk); cyc++;
    end
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[0].data) begin errors++; $display("FAIL rmid_word2: got %b/%h want 1/%h", bus.out_valid, bus.out_data, exp_q[0].data); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid  !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data   !== '0)   begin errors++; $display("FAIL rmid_data: got %h want 0", bus.out_data); end
    checks++; if (bus.out_byteen !== '0)   begin errors++; $display("FAIL rmid_byteen: got %h want 0", bus.out_byteen); end
    checks++; if (bus.out_last   !== 1'b0) begin errors++; $display("FAIL rmid_last: got %b want 0", bus.out_last); end
    checks++; if (bus.in_ready   !== 1'b0) begin errors++; $display("FAIL rmid_in_ready: got %b want 0", bus.in_ready); end
    exp_q.delete();
    exp_stat = 0;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_recover: ready/valid=%b%b want 10", bus.in_ready, bus.out_valid); end
    test_identity();
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_sel     = '0;
    bus.in_lane_en = '0;
    bus.out_ready  = 1'b0;
    @(negedge clk);
    test_reset();
    test_identity();
    test_full_conflict();
    test_partial();
    test_backpressure();
    test_empty();
    test_random();
    test_reset_mid();
    test_empty();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
